// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with glitch-rejecting start detection and a
// one-entry valid/ready holding register.
//
// Ports:
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   ser_rx       asynchronous serial line, idles high
//   rx_data      received byte, valid while rx_valid is high
//   rx_valid     byte available, held until accepted
//   rx_ready     consumer accept; transfer on rx_valid & rx_ready
//   rx_busy      high while the receive FSM is not idle
//   frame_err    one-cycle pulse when the stop bit is sampled low
//   overrun_err  one-cycle pulse when a completed byte is dropped
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // Synchronizer and edge-detect flops; all idle-high.
  logic sync1_q, sync1_d;
  logic rxs_q, rxs_d;
  logic rxs_prev_q, rxs_prev_d;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            oerr_q, oerr_d;

  logic byte_done;
  logic stop_bad;

  always_comb begin
    sync1_d    = ser_rx;
    rxs_d      = sync1_q;
    rxs_prev_d = rxs_q;
  end

  // Receive FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Only a genuine high-to-low edge starts a frame.
        if (rxs_prev_q && !rxs_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          // Leave at mid stop bit so back-to-back frames are not missed.
          cnt_d     = '0;
          state_d   = StIdle;
          byte_done = rxs_q;
          stop_bad  = !rxs_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register and error pulses.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = stop_bad;
    oerr_d  = 1'b0;

    if (byte_done) begin
      // A simultaneous accept frees the slot for the new byte.
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        oerr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      rxs_q      <= rxs_d;
      rxs_prev_q <= rxs_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      oerr_q     <= oerr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = (state_q != StIdle);
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT = 16.
module tb_uart_rx;

  localparam int Cpb = 16;

  logic       clk;
  logic       resetn;
  logic       ser_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;

  uart_rx #(
    .CLK_FREQ (1_600_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ser_rx     (ser_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int fails  = 0;

  logic [7:0] exp_q[$];
  int ferr_cnt     = 0;
  int oerr_cnt     = 0;
  int valid_cycles = 0;
  int rx_count     = 0;
  int rx_cycle     = 0;
  bit busy_seen    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (frame_err) ferr_cnt++;
      if (overrun_err) oerr_cnt++;
      if (rx_valid) valid_cycles++;
      if (rx_busy) busy_seen = 1'b1;
      if (rx_valid && rx_ready) begin
        logic [7:0] exp_b;
        rx_count++;
        rx_cycle = cyc;
        check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(exp_b));
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame; returns the cycle stamp of the start edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    @(posedge clk);
    #1;
    ser_rx    = 1'b0;
    start_cyc = cyc;
    wait_cycles(Cpb);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      wait_cycles(Cpb);
    end
    ser_rx = stop_bit;
    wait_cycles(Cpb);
    ser_rx = 1'b1;
  endtask

  task automatic clear_counts();
    ferr_cnt     = 0;
    oerr_cnt     = 0;
    valid_cycles = 0;
    busy_seen    = 1'b0;
  endtask

  initial begin
    int t0;
    resetn   = 1'b0;
    ser_rx   = 1'b1;
    rx_ready = 1'b0;
    wait_cycles(5);
    @(negedge clk);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_cycles(100);
    check("idle_valid", 32'(rx_valid), 32'd0);
    check("idle_busy", 32'(rx_busy), 32'd0);
    check("idle_errs", 32'(ferr_cnt + oerr_cnt + valid_cycles), 32'd0);

    // Single byte with consumer ready.
    clear_counts();
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, t0);
    wait_cycles(10);
    check("a5_count", 32'(rx_count), 32'd1);
    check("a5_pulse_len", 32'(valid_cycles), 32'd1);
    check("a5_latency_ok", 32'((rx_cycle - t0) >= 154 && (rx_cycle - t0) <= 156), 32'd1);
    check("a5_no_err", 32'(ferr_cnt + oerr_cnt), 32'd0);

    // Overrun: two back-to-back bytes, consumer stalled.
    clear_counts();
    rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, t0);
    send_byte(8'hC3, 1'b1, t0);
    wait_cycles(10);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_data_held", 32'(rx_data), 32'h3C);
    check("ovr_pulse", 32'(oerr_cnt), 32'd1);
    check("ovr_no_ferr", 32'(ferr_cnt), 32'd0);
    rx_ready = 1'b1;
    wait_cycles(5);
    check("ovr_count", 32'(rx_count), 32'd2);
    check("ovr_valid_drop", 32'(rx_valid), 32'd0);
    check("ovr_q_empty", 32'(exp_q.size()), 32'd0);

    // Framing error, then a clean byte.
    clear_counts();
    send_byte(8'h55, 1'b0, t0);
    wait_cycles(10);
    check("ferr_pulse", 32'(ferr_cnt), 32'd1);
    check("ferr_no_valid", 32'(valid_cycles), 32'd0);
    check("ferr_idle", 32'(rx_busy), 32'd0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, t0);
    wait_cycles(10);
    check("ferr_next_count", 32'(rx_count), 32'd3);

    // Short glitch is rejected.
    clear_counts();
    @(posedge clk);
    #1;
    ser_rx = 1'b0;
    wait_cycles(4);
    ser_rx = 1'b1;
    wait_cycles(30);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy_low", 32'(rx_busy), 32'd0);
    check("glitch_quiet", 32'(valid_cycles + ferr_cnt + oerr_cnt), 32'd0);

    // Reset mid-frame aborts 0xFF.
    @(posedge clk);
    #1;
    ser_rx = 1'b0;
    wait_cycles(Cpb);
    ser_rx = 1'b1;
    wait_cycles(Cpb * 4 + 8);
    resetn = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    check("rst_mid_valid", 32'(rx_valid), 32'd0);
    check("rst_mid_data", 32'(rx_data), 32'd0);
    check("rst_mid_busy", 32'(rx_busy), 32'd0);
    check("rst_mid_errs", 32'({frame_err, overrun_err}), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_cycles(Cpb * 5);
    check("rst_no_ff", 32'(rx_count), 32'd3);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, t0);
    wait_cycles(10);
    check("rst_12_count", 32'(rx_count), 32'd4);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the SoC serial input `ser_rx`.
- Counterpart of the existing transmit path that drives `ser_tx`.
- Oversamples the line with the system clock and rejects glitched start bits.
- Delivers each received byte over a valid/ready handshake through a one-entry holding register, and reports framing and overrun errors.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz (20 ns period).
- BAUD_RATE, 115_200, line bit rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434 at defaults), derived localparam. Must be >= 4; HALF_BIT = CLKS_PER_BIT/2, truncated.

Ports:
- clk  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous reset, active low; deasserted synchronously to clk.
- ser_rx  in  1  asynchronous serial line; idles high.
- rx_data  out  8  received byte; valid while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accept; a transfer occurs when rx_valid & rx_ready on a rising clk edge.
- rx_busy  out  1  high whenever the FSM is not IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err  out  1  one-cycle pulse: a completed byte was dropped.

Behaviour:
- Reset: one clock, `clk`; asynchronous active-low reset `resetn`. While resetn=0:
  - Outputs: rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, overrun_err=0.
  - Internal state: synchronizer flops=1, FSM=IDLE, counters=0.
  - Reset asserted mid-frame aborts the frame immediately and discards any held byte.
- Input sync: ser_rx passes through a 2-flop synchronizer (both flops reset to 1); `rxs` is the second flop. A third flop holds rxs delayed by one cycle, for edge detection.
- FSM states: IDLE, START, DATA, STOP. A bit-period counter counts 0..CLKS_PER_BIT-1; a bit index counts 0..7.
- IDLE:
  - On a falling edge of rxs (previous rxs=1, current rxs=0): go to START and clear the counter.
  - A line that is low coming out of reset does not start a frame; a high-to-low edge is required.
- START:
  - When the counter reaches HALF_BIT-1, sample rxs.
  - Sample 0: go to DATA with counter=0 and bit index=0.
  - Sample 1: glitch; return to IDLE with no output and no error.
- DATA:
  - When the counter reaches CLKS_PER_BIT-1, sample rxs into a shift register, LSB first (bit index 0 = rx_data[0]).
  - After index 7, go to STOP with counter=0.
- STOP:
  - At counter=CLKS_PER_BIT-1 (mid stop bit), sample rxs, then return to IDLE on the next cycle.
  - This allows back-to-back frames with a stop bit of nominal length.
  - Stop sample 1: byte is complete; apply the holding rules below.
  - Stop sample 0: frame_err pulses for 1 cycle and the byte is discarded; rx_valid and rx_data are unchanged.
- Holding register, evaluated on the byte-complete cycle:
  - rx_valid=0: load rx_data; rx_valid=1 next cycle.
  - rx_valid=1 and rx_ready=1 (simultaneous accept): old byte transfers, new byte loads, rx_valid stays 1.
  - rx_valid=1 and rx_ready=0: new byte dropped, old byte retained, overrun_err pulses for 1 cycle.
- Handshake:
  - rx_valid falls the cycle after a transfer unless a new byte loads in that same cycle.
  - rx_data is stable while rx_valid=1 and no transfer occurs.
  - rx_ready while rx_valid=0 has no effect.
- Latency: rx_valid rises 2+HALF_BIT+9*CLKS_PER_BIT+1 cycles (±1) after the ser_rx start edge. At defaults that is 217+3906+3 ≈ 4126 cycles.
- Tolerance: correct reception with the transmitter baud off by up to ±2 %.
- rx_busy is asserted from the START entry through the STOP exit.

Test Plan:
- Setup: CLK_FREQ=1_600_000 and BAUD_RATE=100_000 (CLKS_PER_BIT=16). Release reset with ser_rx=1, hold 100 cycles.
  -> All outputs remain 0; rx_busy=0.
- Send 0xA5 as 8N1 with rx_ready=1.
  -> rx_valid pulses for 1 cycle with rx_data=8'hA5, 2+8+144+1 (±1) cycles after the start edge.
  -> No error pulses.
- With rx_ready=0, send 0x3C then 0xC3 back-to-back.
  -> rx_data=8'h3C held with rx_valid=1.
  -> overrun_err pulses once at the second stop sample.
  -> Raising rx_ready then yields 0x3C only.
- Send 0x55 with the stop bit forced low.
  -> frame_err pulses once; rx_valid stays 0; the FSM returns to IDLE.
  -> A following 0x81 is received correctly.
- Drive a 4-cycle low glitch on ser_rx.
  -> FSM enters START and returns to IDLE; no rx_valid, no errors; rx_busy goes high then low.
- Assert resetn=0 during bit 4 of 0xFF, release, then send 0x12.
  -> Outputs are 0 during reset; 0xFF is never delivered; 0x12 is received correctly.
